// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Digit-serial a - b - bin, DIGIT bits per clock, LSB digit first,
//            with start/done handshake and borrow/overflow/zero flags.
// Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [DIGIT-1:0] w_a_dig, w_b_dig;
    logic [DIGIT:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_last;

    // Current digit slice, its difference, and the working result with it merged in.
    always_comb begin
        w_a_dig = '0;
        w_b_dig = '0;
        w_res   = res_q;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                w_a_dig = a_q[k*DIGIT +: DIGIT];
                w_b_dig = b_q[k*DIGIT +: DIGIT];
            end
        end
        w_sum = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {{DIGIT{1'b0}}, br_q};
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                w_res[k*DIGIT +: DIGIT] = w_sum[DIGIT-1:0];
            end
        end
        w_last = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                res_d = w_res;
                br_d  = w_sum[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (w_last) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    diff_d   = w_res;
                    borrow_d = w_sum[DIGIT];
                    zero_d   = (w_res == '0);
                    ovf_d    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ w_res[WIDTH-1]);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign difference = diff_q;
    assign borrow     = borrow_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Scoreboard bench over four (WIDTH, DIGIT) configurations.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int NCFG = 4;
    localparam int CFG_W [NCFG] = '{16, 4, 8, 12};
    localparam int CFG_D [NCFG] = '{4, 1, 8, 3};

    localparam int NDIR = 6;
    localparam logic [31:0] DIR_A [NDIR] = '{32'h1234, 32'h0000, 32'h8000, 32'h0005, 32'h7FFF, 32'h8000};
    localparam logic [31:0] DIR_B [NDIR] = '{32'h0234, 32'h0001, 32'h0001, 32'h0004, 32'hFFFF, 32'h7FFF};
    localparam logic        DIR_C [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    bit fin [NCFG];

    task automatic chk(input int id, input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL cfg%0d %s: got %h expected %h", id, nm, act, exp);
    endtask

    generate
        for (genvar g = 0; g < NCFG; g++) begin : g_cfg
            localparam int W = CFG_W[g];
            localparam int D = CFG_D[g];
            localparam int N = W / D;

            logic         rst_n, start, bin_s, busy, done, borrow, overflow, zero;
            logic [W-1:0] a_s, b_s, diff;

            logic [W+2:0] exp_q [$];
            logic [W+2:0] held;
            int           phase = 0;
            bit           armed = 1'b0;

            serial_subtractor #(.WIDTH(W), .DIGIT(D)) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .start      (start),
                .a          (a_s),
                .b          (b_s),
                .bin        (bin_s),
                .busy       (busy),
                .done       (done),
                .difference (diff),
                .borrow     (borrow),
                .overflow   (overflow),
                .zero       (zero)
            );

            // Reference: plain integer arithmetic, packed as {diff, borrow, overflow, zero}.
            function automatic logic [W+2:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
                longint ux, uy, sx, sy, raw, sr;
                logic [W-1:0] d;
                logic bo, ov;
                ux  = longint'(x);
                uy  = longint'(y);
                sx  = x[W-1] ? ux - (longint'(1) << W) : ux;
                sy  = y[W-1] ? uy - (longint'(1) << W) : uy;
                raw = ux - uy - longint'(c);
                sr  = sx - sy - longint'(c);
                d   = raw[W-1:0];
                bo  = (raw < 0);
                ov  = (sr < -(longint'(1) << (W-1))) || (sr >= (longint'(1) << (W-1)));
                return {d, bo, ov, (d == '0)};
            endfunction

            // Timing model: phase counts edges since acceptance; done expected at phase N+1.
            initial forever begin
                @(posedge clk);
                if (!rst_n) begin
                    phase = 0;
                    exp_q.delete();
                    held  = '0;
                    armed = 1'b1;
                end else if (phase == 0) begin
                    if (start) begin
                        exp_q.push_back(ref_sub(a_s, b_s, bin_s));
                        phase = 1;
                    end
                end else if (phase == N + 1) begin
                    phase = 0;
                end else begin
                    phase++;
                end
            end

            initial forever begin
                @(negedge clk);
                if (armed) begin
                    chk(g, "busy", 64'(busy), 64'(phase != 0));
                    chk(g, "done", 64'(done), 64'(phase == N + 1));
                    if (done) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            $display("FAIL cfg%0d unexpected_done: got done=1 expected no pending op", g);
                        end else begin
                            held = exp_q.pop_front();
                        end
                    end
                    chk(g, "result{diff,borrow,ovf,zero}", 64'({diff, borrow, overflow, zero}), 64'(held));
                end
            end

            task automatic wait_idle();
                int k = 0;
                while (phase != 0 && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                if (phase != 0) begin
                    total++;
                    $display("FAIL cfg%0d idle_timeout: got phase=%0d expected 0", g, phase);
                end
            endtask

            task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic c);
                wait_idle();
                a_s   = x[W-1:0];
                b_s   = y[W-1:0];
                bin_s = c;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                a_s   = W'($urandom);
                b_s   = W'($urandom);
                bin_s = 1'($urandom);
            endtask

            initial begin
                logic [31:0] iv;
                rst_n = 1'b0;
                start = 1'b0;
                a_s   = '0;
                b_s   = '0;
                bin_s = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;

                for (int i = 0; i < NDIR; i++) do_op(DIR_A[i], DIR_B[i], DIR_C[i]);

                // start held high with changing operands while busy
                wait_idle();
                for (int k = 0; k < 4 * (N + 2); k++) begin
                    start = 1'b1;
                    a_s   = W'($urandom);
                    b_s   = W'($urandom);
                    bin_s = 1'($urandom);
                    @(negedge clk);
                end
                start = 1'b0;

                // reset during RUN, then a fresh operation
                do_op($urandom, $urandom, 1'b1);
                repeat (2) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                do_op(32'h1234, 32'h0234, 1'b0);

                // index sweep (exhaustive for the 4-bit configuration)
                for (int i = 0; i < 512; i++) begin
                    iv = 32'(i);
                    do_op({28'd0, iv[8:5]}, {28'd0, iv[4:1]}, iv[0]);
                end

                for (int i = 0; i < 2500; i++) do_op($urandom, $urandom, 1'($urandom));

                wait_idle();
                repeat (3) @(negedge clk);
                fin[g] = 1'b1;
            end
        end
    endgenerate

    function automatic bit all_fin();
        bit r = 1'b1;
        for (int i = 0; i < NCFG; i++) r &= fin[i];
        return r;
    endfunction

    initial begin
        int cyc = 0;
        while (!all_fin() && cyc < 90000) begin
            @(negedge clk);
            cyc++;
        end
        if (!all_fin()) begin
            total++;
            $display("FAIL global_timeout: got %0d cycles expected all configurations finished", cyc);
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
